// File: rtl/bus_control_sequencer_if.sv
// Bus-side control and snoop lines between the sequencer
// and the common-bus register/memory block.
interface bus_control_sequencer_if;
  logic [15:0] bus_data;
  logic [2:0]  select;
  logic [5:0]  LD;
  logic [4:0]  INR;
  logic [4:0]  CLR;
  logic        read;
  logic        write;
  logic        enable;

  modport master (
    input  bus_data,
    output select, LD, INR, CLR,
    output read, write, enable
  );

  modport slave (
    output bus_data,
    input  select, LD, INR, CLR,
    input  read, write, enable
  );
endinterface

// File: rtl/bus_control_sequencer.sv
// Fetch/decode/execute sequencer driving the common-bus block.
// One registered control word per cycle, derived from the next state.
module bus_control_sequencer #(
  parameter bit CLEAR_PC_ON_START = 1'b1,
  parameter int ADDR_W            = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  bus_control_sequencer_if.master   bus,
  output logic [15:0]               ir_q,
  output logic                      busy,
  output logic                      halted,
  output logic                      instr_done
);

  // Opcode and indirect bit sit directly above the address field.
  localparam int OP_LSB = ADDR_W;

  typedef enum logic [5:0] {
    IDLE, HALT, S0,
    F0, F1, F2, F3, F4, F5, DEC,
    A0, A1, N0, N1, N2, N3,
    L0, L1, L2, L3,
    T0, T1, B0, B1,
    Z0, Z1, Z2, Z3, Z4, Z5, Z6, Z7, Z8, Z9,
    R_CLA, R_INC, R_HLT, NOP
  } state_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [5:0] ld;
    logic [4:0] inr;
    logic [4:0] clr;
    logic       rd;
    logic       wr;
    logic       en;
    logic       done;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [15:0] ir_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;

  function automatic state_t exec_entry(
    input logic [2:0] op
  );
    state_t s;
    case (op)
      3'b010:  s = L0;
      3'b011:  s = T0;
      3'b100:  s = B0;
      3'b110:  s = Z0;
      default: s = NOP;
    endcase
    return s;
  endfunction

  function automatic ctrl_t ctrl_of(
    input state_t s,
    input logic   inc,
    input logic   hlt
  );
    ctrl_t c;
    c = '0;
    case (s)
      S0:  c.clr[1] = 1'b1;
      F0:  c.sel = 3'b010;
      F1:  begin c.sel = 3'b010; c.ld[0] = 1'b1; end
      F3:  begin c.rd = 1'b1; c.inr[1] = 1'b1; end
      F4:  c.sel = 3'b111;
      F5:  begin
        c.sel   = 3'b111;
        c.ld[4] = 1'b1;
        c.en    = 1'b1;
      end
      A0:  c.sel = 3'b101;
      A1:  begin c.sel = 3'b101; c.ld[0] = 1'b1; end
      N1:  c.rd = 1'b1;
      N2:  c.sel = 3'b111;
      N3:  begin c.sel = 3'b111; c.ld[0] = 1'b1; end
      L1:  c.rd = 1'b1;
      L2:  c.sel = 3'b111;
      L3:  begin
        c.sel   = 3'b111;
        c.ld[3] = 1'b1;
        c.done  = 1'b1;
      end
      T0:  c.sel = 3'b100;
      T1:  begin
        c.sel  = 3'b100;
        c.wr   = 1'b1;
        c.done = 1'b1;
      end
      B0:  c.sel = 3'b001;
      B1:  begin
        c.sel   = 3'b001;
        c.ld[1] = 1'b1;
        c.done  = 1'b1;
      end
      Z1:  c.rd = 1'b1;
      Z2:  c.sel = 3'b111;
      Z3:  begin c.sel = 3'b111; c.ld[2] = 1'b1; end
      Z4:  c.inr[2] = 1'b1;
      Z5:  c.sel = 3'b011;
      Z6:  begin
        c.sel = 3'b011;
        c.wr  = 1'b1;
        c.en  = 1'b1;
      end
      Z8:  begin c.inr[1] = 1'b1; c.done = 1'b1; end
      Z9:  c.done = 1'b1;
      R_CLA: begin
        c.clr[3] = 1'b1;
        c.done   = !inc && !hlt;
      end
      R_INC: begin
        c.inr[3] = 1'b1;
        c.done   = !hlt;
      end
      R_HLT: c.done = 1'b1;
      NOP:   c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: if (start) state_d = CLEAR_PC_ON_START ? S0 : F0;
      HALT: if (start) state_d = F0;
      S0:   state_d = F0;
      F0:   state_d = F1;
      F1:   state_d = F2;
      F2:   state_d = F3;
      F3:   state_d = F4;
      F4:   state_d = F5;
      F5:   state_d = DEC;
      DEC: begin
        ir_d = bus.bus_data;
        if (ir_d[OP_LSB +: 3] != 3'b111) state_d = A0;
        else if (ir_d[7])                state_d = R_CLA;
        else if (ir_d[5])                state_d = R_INC;
        else if (ir_d[0])                state_d = R_HLT;
        else                             state_d = NOP;
      end
      A0:   state_d = A1;
      A1:   state_d = ir_q[OP_LSB+3] ? N0
                    : exec_entry(ir_q[OP_LSB +: 3]);
      N0:   state_d = N1;
      N1:   state_d = N2;
      N2:   state_d = N3;
      N3:   state_d = exec_entry(ir_q[OP_LSB +: 3]);
      L0:   state_d = L1;
      L1:   state_d = L2;
      L2:   state_d = L3;
      T0:   state_d = T1;
      B0:   state_d = B1;
      Z0:   state_d = Z1;
      Z1:   state_d = Z2;
      Z2:   state_d = Z3;
      Z3:   state_d = Z4;
      Z4:   state_d = Z5;
      Z5:   state_d = Z6;
      Z6:   state_d = Z7;
      // Snooped DR after write-back; 0000 includes the FFFF wrap.
      Z7:   state_d = (bus.bus_data == 16'h0) ? Z8 : Z9;
      R_CLA: state_d = ir_q[5] ? R_INC
                     : ir_q[0] ? R_HLT : F0;
      R_INC: state_d = ir_q[0] ? R_HLT : F0;
      R_HLT: state_d = HALT;
      L3, T1, B1, Z8, Z9, NOP: state_d = F0;
      default: state_d = IDLE;
    endcase
    ctrl_d   = ctrl_of(state_d, ir_d[5], ir_d[0]);
    busy_d   = !(state_d inside {IDLE, HALT});
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      ctrl_q   <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ctrl_q   <= ctrl_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign bus.select  = ctrl_q.sel;
  assign bus.LD      = ctrl_q.ld;
  assign bus.INR     = ctrl_q.inr;
  assign bus.CLR     = ctrl_q.clr;
  assign bus.read    = ctrl_q.rd;
  assign bus.write   = ctrl_q.wr;
  assign bus.enable  = ctrl_q.en;
  assign instr_done  = ctrl_q.done;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Directed bench: sequencer plus a behavioural common-bus
// register/memory block, checked per instruction scenario.
module tb_bus_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [15:0] ir_q;
  logic        busy;
  logic        halted;
  logic        instr_done;

  int checks   = 0;
  int failures = 0;

  bus_control_sequencer_if bif();

  bus_control_sequencer #(
    .CLEAR_PC_ON_START(1'b1),
    .ADDR_W(12)
  ) dut (
    .clock(clk),
    .reset(reset),
    .start(start),
    .bus(bif),
    .ir_q(ir_q),
    .busy(busy),
    .halted(halted),
    .instr_done(instr_done)
  );

  // Downstream block model.
  logic [11:0] ar = '0;
  logic [11:0] pc = '0;
  logic [15:0] dr = '0;
  logic [15:0] ac = '0;
  logic [15:0] irr = '0;
  logic [15:0] tr = '0;
  logic [15:0] mem_rd = '0;
  logic [15:0] dout = '0;
  logic [15:0] mem [0:4095] = '{default: 16'h0};
  logic [15:0] bus_v;

  logic        pre_we;
  logic        pre_ac_we;
  logic [11:0] pre_addr;
  logic [15:0] pre_data;

  always_comb begin
    case (bif.select)
      3'b001:  bus_v = {4'h0, ar};
      3'b010:  bus_v = {4'h0, pc};
      3'b011:  bus_v = dr;
      3'b100:  bus_v = ac;
      3'b101:  bus_v = irr;
      3'b110:  bus_v = tr;
      3'b111:  bus_v = mem_rd;
      default: bus_v = 16'h0;
    endcase
  end

  assign bif.bus_data = dout;

  always @(posedge clk) begin
    if (bif.LD[0])       ar <= bus_v[11:0];
    else if (bif.INR[0]) ar <= ar + 12'd1;
    else if (bif.CLR[0]) ar <= '0;
    if (bif.LD[1])       pc <= bus_v[11:0];
    else if (bif.INR[1]) pc <= pc + 12'd1;
    else if (bif.CLR[1]) pc <= '0;
    if (bif.LD[2])       dr <= bus_v;
    else if (bif.INR[2]) dr <= dr + 16'd1;
    else if (bif.CLR[2]) dr <= '0;
    if (bif.LD[3])       ac <= bus_v;
    else if (bif.INR[3]) ac <= ac + 16'd1;
    else if (bif.CLR[3]) ac <= '0;
    if (bif.LD[4])       irr <= bus_v;
    if (bif.LD[5])       tr <= bus_v;
    else if (bif.INR[4]) tr <= tr + 16'd1;
    else if (bif.CLR[4]) tr <= '0;
    if (bif.read)   mem_rd <= mem[ar];
    if (bif.write)  mem[ar] <= bus_v;
    if (bif.enable) dout <= bus_v;
    if (pre_we)     mem[pre_addr] <= pre_data;
    if (pre_ac_we)  ac <= pre_data;
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic poke_mem(input logic [11:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic poke_ac(input logic [15:0] d);
    pre_data  = d;
    pre_ac_we = 1'b1;
    @(negedge clk);
    pre_ac_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (instr_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [24:0] strobes;
    bit seen;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    strobes = {bif.select, bif.LD, bif.INR, bif.CLR,
               bif.read, bif.write, bif.enable};
    checks++;
    if (strobes !== 25'h0) begin
      failures++;
      $display("FAIL reset_strobes got=%h exp=0", strobes);
    end
    checks++;
    if ({busy, halted, instr_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_status got=%b exp=000",
               {busy, halted, instr_done});
    end
    checks++;
    if (ir_q !== 16'h0) begin
      failures++;
      $display("FAIL reset_ir got=%h exp=0000", ir_q);
    end
    reset = 1'b0;
    poke_mem(12'h000, 16'h2005);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bif.LD[0]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_fetch_ar_load got=timeout exp=LD0");
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    strobes = {bif.select, bif.LD, bif.INR, bif.CLR,
               bif.read, bif.write, bif.enable};
    checks++;
    if (strobes !== 25'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort got=%h busy=%b exp=0 busy=0",
               strobes, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bif.read !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b read=%b exp=0 0",
               busy, bif.read);
    end
  endtask

  task automatic test_lda();
    bit ok;
    bit seen;
    do_reset();
    poke_mem(12'h000, 16'h2005);
    poke_mem(12'h005, 16'h1234);
    poke_mem(12'h001, 16'h0000);
    pulse_start();
    wait_done(60, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL lda_done got=timeout exp=pulse");
    end
    @(negedge clk);
    checks++;
    if (ac !== 16'h1234) begin
      failures++;
      $display("FAIL lda_ac got=%h exp=1234", ac);
    end
    checks++;
    if (pc !== 12'h001) begin
      failures++;
      $display("FAIL lda_pc got=%h exp=001", pc);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bif.LD[0]) seen = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (!seen || ar !== 12'h001) begin
      failures++;
      $display("FAIL lda_next_fetch got=%h seen=%b exp=001", ar, seen);
    end
  endtask

  task automatic test_lda_indirect();
    bit ok;
    do_reset();
    poke_mem(12'h000, 16'hA004);
    poke_mem(12'h004, 16'h0009);
    poke_mem(12'h009, 16'hBEEF);
    poke_mem(12'h001, 16'h7001);
    pulse_start();
    wait_done(60, ok);
    @(negedge clk);
    checks++;
    if (!ok || ac !== 16'hBEEF) begin
      failures++;
      $display("FAIL lda_ind_ac got=%h ok=%b exp=beef", ac, ok);
    end
    checks++;
    if (ir_q !== 16'hA004) begin
      failures++;
      $display("FAIL lda_ind_ir got=%h exp=a004", ir_q);
    end
  endtask

  task automatic test_sta_bun();
    bit ok;
    do_reset();
    poke_ac(16'h00AA);
    poke_mem(12'h000, 16'h3007);
    poke_mem(12'h001, 16'h4010);
    poke_mem(12'h007, 16'h0000);
    poke_mem(12'h010, 16'h7001);
    pulse_start();
    wait_done(60, ok);
    @(negedge clk);
    checks++;
    if (!ok || mem[7] !== 16'h00AA) begin
      failures++;
      $display("FAIL sta_mem got=%h ok=%b exp=00aa", mem[7], ok);
    end
    wait_done(60, ok);
    @(negedge clk);
    checks++;
    if (!ok || pc !== 12'h010) begin
      failures++;
      $display("FAIL bun_pc got=%h ok=%b exp=010", pc, ok);
    end
    wait_done(60, ok);
    @(negedge clk);
    checks++;
    if (!ok || halted !== 1'b1 || pc !== 12'h011) begin
      failures++;
      $display("FAIL bun_target got pc=%h halted=%b exp=011 1",
               pc, halted);
    end
  endtask

  task automatic test_isz();
    bit ok;
    do_reset();
    poke_mem(12'h000, 16'h6008);
    poke_mem(12'h008, 16'hFFFF);
    poke_mem(12'h002, 16'h7001);
    pulse_start();
    wait_done(60, ok);
    @(negedge clk);
    checks++;
    if (!ok || mem[8] !== 16'h0000) begin
      failures++;
      $display("FAIL isz_wrap_mem got=%h ok=%b exp=0000", mem[8], ok);
    end
    checks++;
    if (pc !== 12'h002) begin
      failures++;
      $display("FAIL isz_skip_pc got=%h exp=002", pc);
    end
    wait_done(60, ok);
    @(negedge clk);
    checks++;
    if (!ok || halted !== 1'b1) begin
      failures++;
      $display("FAIL isz_skip_halt got=%b exp=1", halted);
    end
    do_reset();
    poke_mem(12'h008, 16'h0003);
    poke_mem(12'h001, 16'h7001);
    pulse_start();
    wait_done(60, ok);
    @(negedge clk);
    checks++;
    if (!ok || mem[8] !== 16'h0004) begin
      failures++;
      $display("FAIL isz_inc_mem got=%h ok=%b exp=0004", mem[8], ok);
    end
    checks++;
    if (pc !== 12'h001) begin
      failures++;
      $display("FAIL isz_noskip_pc got=%h exp=001", pc);
    end
  endtask

  task automatic test_regref_halt();
    bit ok;
    do_reset();
    poke_ac(16'h5555);
    poke_mem(12'h000, 16'h70A0);
    poke_mem(12'h001, 16'h7001);
    poke_mem(12'h002, 16'h7001);
    pulse_start();
    wait_done(60, ok);
    @(negedge clk);
    checks++;
    if (!ok || ac !== 16'h0001) begin
      failures++;
      $display("FAIL cla_inc_ac got=%h ok=%b exp=0001", ac, ok);
    end
    wait_done(60, ok);
    @(negedge clk);
    checks++;
    if (!ok || halted !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hlt_state got halted=%b busy=%b exp=1 0",
               halted, busy);
    end
    checks++;
    if (pc !== 12'h002) begin
      failures++;
      $display("FAIL hlt_pc got=%h exp=002", pc);
    end
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bif.CLR[1] !== 1'b0) begin
      failures++;
      $display("FAIL resume_busy got busy=%b clr1=%b exp=1 0",
               busy, bif.CLR[1]);
    end
    wait_done(60, ok);
    @(negedge clk);
    checks++;
    if (!ok || pc !== 12'h003 || ar !== 12'h002) begin
      failures++;
      $display("FAIL resume_fetch got pc=%h ar=%h exp=003 002",
               pc, ar);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    pre_we    = 1'b0;
    pre_ac_we = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;
    @(negedge clk);
    test_reset();
    test_lda();
    test_lda_indirect();
    test_sta_bun();
    test_isz();
    test_regref_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_control_sequencer.md
Name: bus_control_sequencer

Overview:
- Control unit that sits directly upstream of the 16-bit common-bus register/memory block.
- Drives that block's select, LD, INR, CLR, read, write and enable lines so it fetches, decodes and executes a small instruction set.
- Gets instruction and data values back by snooping the block's data_out port, with enable asserted.
- Transfers are two-phase: the source is selected in cycle k, and the destination is loaded in cycle k+1 with the same select held.

Parameters:
- CLEAR_PC_ON_START, 1, when 1 a start from IDLE issues CLR[1] (PC<=0) before the first fetch.
- ADDR_W, 12, address width; IR[ADDR_W-1:0] is the operand address.

Ports:
- clock  in  1  single system clock; all outputs are registered on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- start  in  1  pulse; leaves IDLE or HALT and begins fetching.
- bus_data  in  16  snooped value of the downstream data_out.
- select  out  3  bus source: 000 ext, 001 AR, 010 PC, 011 DR, 100 AC, 101 IR, 110 TR, 111 memory.
- LD  out  6  load strobes: [0]AR [1]PC [2]DR [3]AC [4]IR [5]TR.
- INR  out  5  increment strobes: [0]AR [1]PC [2]DR [3]AC [4]TR.
- CLR  out  5  clear strobes, same bit order as INR.
- read  out  1  memory read strobe.
- write  out  1  memory write strobe (writes the bus value to memory at AR).
- enable  out  1  downstream data_out update.
- ir_q  out  16  sequencer's captured copy of IR.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.

Behaviour:
- Reset:
  - All outputs 0, ir_q=0, state IDLE.
  - Reset mid-instruction aborts it; no read, write, LD, INR or CLR is issued in the cycle after reset is sampled.
- One control word per cycle. At most one of LD/INR/CLR targets a given register in any cycle.
- IDLE / HALT:
  - All strobes 0.
  - start -> S0 (one cycle of CLR[1]) if CLEAR_PC_ON_START, else F0.
  - start is ignored while busy.
- Fetch:
  - F0: sel=010.
  - F1: sel=010, LD[0].
  - F2: address settle, strobes 0.
  - F3: read, INR[1].
  - F4: sel=111.
  - F5: sel=111, LD[4], enable.
  - DEC: ir_q<=bus_data; branch on ir_q[14:12] and the indirect bit ir_q[15].
- Address phase (opcode != 111):
  - A0: sel=101.
  - A1: sel=101, LD[0] (AR<=IR[11:0]; the upper IR bits are truncated downstream).
  - If ir_q[15]=1, the indirect phase follows: settle, read, sel=111, then sel=111 with LD[0].
- Execute:
  - 010 LDA: settle, read, sel=111, then sel=111 with LD[3].
  - 011 STA: sel=100 (settle), then sel=100 with write.
  - 100 BUN: sel=001, then sel=001 with LD[1].
  - 110 ISZ, in order:
    - settle
    - read
    - sel=111
    - sel=111 with LD[2]
    - INR[2]
    - sel=011
    - sel=011 with write and enable
    - CHK: if bus_data==0, INR[1] (skip); 16-bit wrap FFFF->0000 counts as zero.
  - 111 register-reference, bits acted on in this fixed order, one cycle each, only if set:
    - ir_q[7] CLA: CLR[3].
    - ir_q[5] INC: INR[3].
    - ir_q[0] HLT: enter HALT after instr_done.
    - CLA+INC together yields AC=1.
  - 000, 001, 101: no operation.
- instr_done pulses in the final execute cycle, then F0, except after HLT.
- PC increments modulo 2^ADDR_W; no overflow flag.

Test Plan:
- Reset held 3 cycles, then released -> all strobes 0, busy=0, ir_q=0; reset asserted at F3 -> no read, next state IDLE.
- M[0]=0x2005 (LDA 5), M[5]=0x1234, start -> AC=0x1234, PC=1, instr_done once, next fetch from address 1.
- M[0]=0xA004 (LDA indirect 4), M[4]=0x0009, M[9]=0xBEEF -> AC=0xBEEF.
- M[0]=0x3007 (STA 7) with AC=0x00AA -> M[7]=0x00AA; M[0]=0x4010 (BUN 0x010) -> next fetch from 0x010.
- M[0]=0x6008, M[8]=0xFFFF -> M[8]=0x0000, PC=2 (skip); repeat with M[8]=0x0003 -> M[8]=0x0004, PC=1.
- M[0]=0x70A0 (CLA+INC), M[1]=0x7001 (HLT) -> AC=1, halted=1, busy=0; start again -> resumes fetch at PC=2.
